mem_bist_ctrl: RTL and testbench

- Built-in self-test master that sits directly upstream of the single-port memory and drives its valid/wr_rd/addr/wdata request interface.
- Consumes the memory's ready/rdata.
- On a start pulse it runs two passes:
  - Write pass: writes a seeded pattern to every address.
  - Read pass: reads every address back and compares against the expected pattern.
- Reports pass/fail, error count, first failing address and handshake timeout to the test/status logic.

---
 rtl/mem_bist_ctrl.sv | 166 ++++++++++++++++
 tb/tb_mem_bist_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bist_ctrl.sv
// Memory BIST master: writes seed^addr to every word, reads it all back and compares.
// Latency 2 cycles per access with a single-cycle-ready memory; each access waits up to TIMEOUT cycles for mem_ready.
// Backpressure: one outstanding request, held until mem_ready; a missing mem_ready aborts the run with timeout set.
module mem_bist_ctrl #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int TIMEOUT    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      seed,
  output logic                  mem_valid,
  output logic                  mem_wr_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH:0]   err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic                  fail_valid,
  output logic                  timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]         TLIM     = CW'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST     = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   ERR_MAX  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   ERR_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [CW-1:0]         CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, DONE
  } state_t;

  state_t                state;
  logic [WIDTH-1:0]      seed_q;
  logic [CW-1:0]         wcnt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [ADDR_WIDTH:0]   err_nxt;
  logic                  mismatch;
  logic                  at_last;
  logic                  wait_expired;

  // Address is zero-extended or truncated to the data width before mixing with the seed.
  function automatic logic [WIDTH-1:0] pattern(input logic [WIDTH-1:0] s,
                                               input logic [ADDR_WIDTH-1:0] a);
    return s ^ WIDTH'(a);
  endfunction

  assign addr_nxt     = mem_addr + ADDR_ONE;
  assign at_last      = (mem_addr == LAST);
  assign mismatch     = (mem_rdata != pattern(seed_q, mem_addr));
  assign err_nxt      = (err_count == ERR_MAX) ? err_count : err_count + ERR_ONE;
  assign wait_expired = (wcnt == TLIM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      seed_q     <= '0;
      wcnt       <= '0;
      mem_valid  <= 1'b0;
      mem_wr_rd  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_addr  <= '0;
      fail_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            seed_q     <= seed;
            mem_addr   <= '0;
            mem_wr_rd  <= 1'b1;
            mem_wdata  <= pattern(seed, '0);
            mem_valid  <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_addr  <= '0;
            fail_valid <= 1'b0;
            timeout    <= 1'b0;
            state      <= WR_REQ;
          end
        end
        WR_REQ: begin
          mem_valid <= 1'b0;
          wcnt      <= '0;
          state     <= WR_WAIT;
        end
        WR_WAIT: begin
          if (mem_ready) begin
            mem_valid <= 1'b1;
            if (at_last) begin
              mem_addr  <= '0;
              mem_wr_rd <= 1'b0;
              mem_wdata <= pattern(seed_q, '0);
              state     <= RD_REQ;
            end else begin
              mem_addr  <= addr_nxt;
              mem_wdata <= pattern(seed_q, addr_nxt);
              state     <= WR_REQ;
            end
          end else if (wait_expired) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= 1'b0;
            state   <= DONE;
          end else begin
            wcnt <= wcnt + CNT_ONE;
          end
        end
        RD_REQ: begin
          mem_valid <= 1'b0;
          wcnt      <= '0;
          state     <= RD_WAIT;
        end
        RD_WAIT: begin
          if (mem_ready) begin
            if (mismatch) begin
              err_count <= err_nxt;
              if (!fail_valid) begin
                fail_addr  <= mem_addr;
                fail_valid <= 1'b1;
              end
            end
            // The final compare lands on the same edge as DONE, so pass folds it in.
            if (at_last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_count == '0) && !mismatch;
              state <= DONE;
            end else begin
              mem_addr  <= addr_nxt;
              mem_wdata <= pattern(seed_q, addr_nxt);
              mem_valid <= 1'b1;
              state     <= RD_REQ;
            end
          end else if (wait_expired) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= 1'b0;
            state   <= DONE;
          end else begin
            wcnt <= wcnt + CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: directed runs against a 1-cycle-ready memory with fault injection,
// checked every cycle against a run-timeline model plus hand-computed literals.
module tb_mem_bist_ctrl;
  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  seed = '0;
  logic          mem_valid, mem_wr_rd;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wdata;
  logic [W-1:0]  mem_rdata = '0;
  logic          mem_ready;
  logic          busy, done, pass, fail_valid, timeout;
  logic [AW:0]   err_count;
  logic [AW-1:0] fail_addr;

  always #5 clk = ~clk;

  mem_bist_ctrl #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed),
    .mem_valid(mem_valid), .mem_wr_rd(mem_wr_rd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_addr(fail_addr), .fail_valid(fail_valid), .timeout(timeout)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: ready and read data appear in the cycle after the request cycle.
  logic [W-1:0]  mem [D];
  logic [W-1:0]  fmask [D];
  logic          mem_en = 1'b1;
  logic          rdy_m = 1'b0;
  logic          stray = 1'b0;
  logic          pend_v = 1'b0, pend_wr = 1'b0;
  logic [AW-1:0] pend_a = '0;
  assign mem_ready = rdy_m | stray;

  initial begin
    for (int i = 0; i < D; i++) begin mem[i] = '0; fmask[i] = '0; end
    forever begin
      @(negedge clk);
      rdy_m = mem_en && pend_v;
      if (mem_en && pend_v && !pend_wr) mem_rdata = mem[pend_a] ^ fmask[pend_a];
      pend_v  = mem_en && mem_valid;
      pend_wr = mem_wr_rd;
      pend_a  = mem_addr;
      if (mem_en && mem_valid && mem_wr_rd) mem[mem_addr] = mem_wdata;
    end
  end

  // Model: a run is a timeline of edges since the accepting edge; a normal run ends at 4*D,
  // a run against a silent memory ends 1+8 edges in. Read of addr a completes at edge 2*D+2+2a.
  bit          m_run = 0, m_tmode = 0, m_wb = 0;
  int          m_n = 0, m_end = 0;
  logic [W-1:0] m_seed = '0;
  logic [W-1:0] m_fmask [D];
  int          cyc = 0, cyc0 = 0, vcnt = 0;

  always @(posedge clk) begin
    cyc++;
    vcnt += int'(mem_valid);
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_run = 0; m_n = 0; m_end = 0; m_tmode = 0; m_seed = '0;
    end else begin
      m_wb = m_run && (m_n < m_end);
      if (m_wb) m_n++;
      if (start && !m_wb) begin
        m_run = 1; m_n = 0; m_seed = seed; m_tmode = !mem_en;
        m_end = m_tmode ? 9 : 4 * D;
        for (int i = 0; i < D; i++) m_fmask[i] = fmask[i];
      end
    end
  end

  bit   e_busy, e_done, e_valid, e_wr, e_fv;
  int   e_errs, e_fa, e_addr, k;
  logic [W-1:0] e_wdata;
  logic [31:0]  e_a32;

  always @(negedge clk) begin
    e_busy = m_run && (m_n < m_end);
    e_done = m_run && (m_n >= m_end);
    k = (m_n < m_end) ? m_n : m_end;
    e_errs = 0; e_fv = 0; e_fa = 0;
    if (m_run && !m_tmode)
      for (int a = 0; a < D; a++)
        if (m_fmask[a] != 0 && (2 * D + 2 + 2 * a) <= k) begin
          if (!e_fv) begin e_fv = 1; e_fa = a; end
          e_errs++;
        end
    e_valid = e_busy && (m_tmode ? (m_n == 0) : (m_n % 2 == 0));
    e_addr  = m_tmode ? 0 : ((m_n / 2) % D);
    e_wr    = m_tmode ? 1'b1 : ((m_n / 2) < D);
    e_a32   = e_addr;
    e_wdata = m_seed ^ e_a32[W-1:0];
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("mem_valid", mem_valid, e_valid);
    chk("err_count", err_count, e_errs);
    chk("fail_valid", fail_valid, e_fv);
    chk("fail_addr", fail_addr, e_fa);
    chk("timeout", timeout, e_done && m_tmode);
    chk("pass", pass, e_done && e_errs == 0 && !m_tmode);
    if (!m_run) begin
      chk("mem_addr_idle", mem_addr, 0);
      chk("mem_wr_rd_idle", mem_wr_rd, 0);
      chk("mem_wdata_idle", mem_wdata, 0);
    end else if (e_busy) begin
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wr_rd", mem_wr_rd, e_wr);
      chk("mem_wdata", mem_wdata, e_wdata);
    end
  end

  task automatic start_run(input logic [W-1:0] s);
    @(negedge clk);
    seed = s; start = 1'b1; vcnt = 0;
    @(negedge clk);
    start = 1'b0;
    cyc0 = cyc;
  endtask

  task automatic wait_done(output int edges);
    int lim = 0;
    while (!done && lim < 300) begin @(negedge clk); lim++; end
    if (!done) chk("wait_done_bound", 0, 1);
    edges = cyc - cyc0;
  endtask

  task automatic set_faults(input logic [D-1:0] which, input logic [W-1:0] m);
    for (int i = 0; i < D; i++) fmask[i] = which[i] ? m : '0;
  endtask

  int edges;
  int lim;

  initial begin
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_valid", mem_valid, 0);
    chk("reset_err", err_count, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal run, seed A5
    start_run(8'hA5);
    lim = 0;
    while (!(mem_valid && mem_wr_rd && mem_addr == 4'd3) && lim < 100) begin @(negedge clk); lim++; end
    chk("nominal_wdata_addr3", mem_wdata, 8'hA6);
    wait_done(edges);
    chk("nominal_latency", edges, 64);
    chk("nominal_pass", pass, 1);
    chk("nominal_err", err_count, 0);
    chk("nominal_fv", fail_valid, 0);

    // Single fault at addr 5, bit 0
    set_faults(16'h0020, 8'h01);
    start_run(8'h00);
    wait_done(edges);
    chk("single_err", err_count, 1);
    chk("single_faddr", fail_addr, 5);
    chk("single_fv", fail_valid, 1);
    chk("single_pass", pass, 0);
    chk("single_timeout", timeout, 0);

    // Faults at 3, 9, 12
    set_faults(16'h1208, 8'h40);
    start_run(8'h5A);
    wait_done(edges);
    chk("multi_err", err_count, 3);
    chk("multi_faddr", fail_addr, 3);
    chk("multi_pass", pass, 0);

    // Stray ready while in DONE must not disturb results
    @(negedge clk); stray = 1'b1;
    @(negedge clk); stray = 1'b0;
    @(negedge clk);
    chk("stray_err", err_count, 3);
    chk("stray_done", done, 1);

    // Fault-free run with a busy start at write addr 4, then restart from DONE
    set_faults(16'h0000, 8'h00);
    start_run(8'h77);
    while (cyc - cyc0 < 8) @(negedge clk);
    seed = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(edges);
    chk("busy_start_latency", edges, 64);
    chk("busy_start_pass", pass, 1);

    set_faults(16'h0400, 8'h10);
    start_run(8'hC3);
    wait_done(edges);
    chk("pre_restart_err", err_count, 1);
    set_faults(16'h0000, 8'h00);
    start_run(8'h3C);
    chk("restart_cleared_err", err_count, 0);
    chk("restart_cleared_done", done, 0);
    chk("restart_wdata0", mem_wdata, 8'h3C);
    wait_done(edges);
    chk("restart_pass", pass, 1);
    chk("restart_latency", edges, 64);

    // Every word faulty: count reaches DEPTH
    set_faults(16'hFFFF, 8'h80);
    start_run(8'h11);
    wait_done(edges);
    chk("allfault_err", err_count, 16);
    chk("allfault_faddr", fail_addr, 0);
    set_faults(16'h0000, 8'h00);

    // Silent memory: timeout after 8 wait cycles
    mem_en = 1'b0;
    start_run(8'h42);
    wait_done(edges);
    chk("timeout_latency", edges, 9);
    chk("timeout_flag", timeout, 1);
    chk("timeout_pass", pass, 0);
    chk("timeout_busy", busy, 0);
    repeat (5) @(negedge clk);
    chk("timeout_valid_pulses", vcnt, 1);
    mem_en = 1'b1;
    start_run(8'h24);
    wait_done(edges);
    chk("after_timeout_pass", pass, 1);

    // Asynchronous reset during the read of addr 7
    start_run(8'h96);
    while (cyc - cyc0 < 47) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midreset_busy", busy, 0);
    chk("midreset_valid", mem_valid, 0);
    chk("midreset_addr", mem_addr, 0);
    chk("midreset_wdata", mem_wdata, 0);
    chk("midreset_err", err_count, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    start_run(8'h69);
    wait_done(edges);
    chk("post_reset_latency", edges, 64);
    chk("post_reset_pass", pass, 1);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
